mskaes_sr_colbuf: RTL and testbench
===================================

# mskaes_sr_colbuf

Masked column buffer with ShiftRows for the 32-bit datapath of the masked AES core. It collects the four SubBytes output columns of a 128-bit masked state. It then streams them out one column per cycle, with the ShiftRows permutation already applied, into the masked MixColumns stage directly downstream. The block is purely sharewise: it routes bytes and never combines shares, so it adds no randomness requirement.

## Interface
- `d`, 2, number of shares per bit. Each masked byte is `8*d` bits wide, and the `d` shares of bit `b` occupy bits `[b*d +: d]`.
- `clk`  in  1  clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input column offered.
- `in_ready`  out  1  block accepts an input column this cycle.
- `in_a0`..`in_a3`  in  `8*d` each  masked bytes of the input column, rows 0..3.
- `out_valid`  out  1  output column presented.
- `out_ready`  in  1  downstream (MixColumns feeder) consumes the column.
- `out_b0`..`out_b3`  out  `8*d` each  masked bytes of the output column after ShiftRows, rows 0..3.
- `out_idx`  out  2  index (0..3) of the column currently presented.
- `out_last`  out  1  high while column 3 is presented.

## Operation
- Storage is 16 masked byte registers `S[c][r]` (column `c`, row `r`), all reset to 0.
- The FSM has two states: FILL (reset state) and DRAIN. A 2-bit counter `cnt` resets to 0.
- In FILL:
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid & in_ready`, write `S[cnt][r] <= in_a{r}` for every row, then `cnt <= cnt+1`.
  - On the accept with `cnt == 3`: `cnt` wraps to 0 and the state goes to DRAIN.
- In DRAIN:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_b{r} = S[(cnt+r) mod 4][r]`, `out_idx = cnt`, `out_last = (cnt == 3)`.
  - On `out_valid & out_ready`, `cnt <= cnt+1`.
  - On the consume with `cnt == 3`: `cnt` wraps to 0 and the state goes to FILL.
- Outputs are driven only from registers and state, with no combinational path from `in_*` to `out_*`. `in_ready` depends only on state.
- Share independence: output share `s` of each bit depends only on input share `s` of the same bit. No XOR or other gate merges shares.
- Storage is not cleared between states. After DRAIN, `S` keeps the old state until it is overwritten in FILL.
- `in_valid` held high during DRAIN is ignored: no write happens and `cnt` does not advance.
- `out_ready` asserted during FILL is ignored.
- Reset asserted mid-FILL or mid-DRAIN:
  - Immediately forces FILL, `cnt = 0`, `S = 0`, `out_valid = 0`, `in_ready = 1`.
  - A partial state is discarded.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_idx` = 0.
  - `out_last` = 0.
  - `out_b0..3` = 0 (`S` = 0, `cnt` = 0).
- Latency: if the 4th input is accepted in cycle `t`, column 0 is presented with `out_valid` = 1 in cycle `t+1`.
- Throughput with both sides always ready: 4 accept cycles, then 4 drain cycles. That is 8 cycles per state with no idle cycle between phases.
- Back-to-back operation: if the last output is consumed in cycle `t`, then `in_ready` = 1 in cycle `t+1`.
- Stalls: while `out_valid & !out_ready`, all outputs hold stable. While `in_valid` is low in FILL, `cnt` and `S` hold.

## Test plan
- Reset check: assert `nrst` low, then release. Observe `in_ready` = 1, `out_valid` = 0, `out_idx` = 0, `out_last` = 0, and all `out_b*` = 0.
- Basic permutation (`d` = 2, random masks):
  - Stimulus: unmasked byte `S[c][r] = 4c+r`, i.e. 0x00..0x0F column-major, with random second shares. Both sides always ready.
  - Recombined outputs: col0 = {00,05,0A,0F}, col1 = {04,09,0E,03}, col2 = {08,0D,02,07}, col3 = {0C,01,06,0B}. `out_last` is high only on col3.
  - First `out_valid` appears one cycle after the 4th accept.
- Share independence: set all share-1 inputs to 0 and share-0 inputs to 0xFF. Every output bit then has share 0 = 1 and share 1 = 0 at every output byte.
- Back-pressure:
  - Randomly deassert `out_ready` and `in_valid`. Outputs stay stable during stalls, and the column order and values match the basic permutation case.
  - `in_valid` = 1 during DRAIN causes no write. Verify this by presenting a distinct column and checking the next state is unaffected.
- Reset mid-operation: accept 2 columns, pulse `nrst` low, then load a fresh 0x00..0x0F state. Output matches the basic permutation case with no residue from the aborted columns.
- Back-to-back states: load two states in sequence, the second being 0xF0..0xFF column-major. The second drain yields col0 = {F0,F5,FA,FF}, and `in_ready` rises the cycle after the first state's col3 is consumed.

Source files
------------

// File: rtl/mskaes_sr_colbuf_if.sv
// Column handshake bundle between the SubBytes output, the ShiftRows buffer
// and the masked MixColumns feeder. One masked byte is 8*D bits, shares of bit b at [b*D +: D].
`timescale 1ns/1ps
interface mskaes_sr_colbuf_if #(
  parameter int D = 2
);
  localparam int W = 8 * D;

  // Both directions use strict valid/ready: a column transfers on the rising
  // clock edge where valid and ready are both high. The producer holds valid and
  // data stable until that edge. Ready never depends on valid.
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a0;
  logic [W-1:0] in_a1;
  logic [W-1:0] in_a2;
  logic [W-1:0] in_a3;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_b0;
  logic [W-1:0] out_b1;
  logic [W-1:0] out_b2;
  logic [W-1:0] out_b3;
  logic [1:0]   out_idx;
  logic         out_last;

  modport slave (
    input  in_valid, in_a0, in_a1, in_a2, in_a3, out_ready,
    output in_ready, out_valid, out_b0, out_b1, out_b2, out_b3, out_idx, out_last
  );

  modport master (
    output in_valid, in_a0, in_a1, in_a2, in_a3, out_ready,
    input  in_ready, out_valid, out_b0, out_b1, out_b2, out_b3, out_idx, out_last
  );
endinterface

// File: rtl/mskaes_sr_colbuf.sv
// Masked column buffer: collects four SubBytes columns, then streams them out
// one per cycle with ShiftRows applied. Purely sharewise byte routing.
`timescale 1ns/1ps
module mskaes_sr_colbuf #(
  parameter int D = 2
) (
  input  logic                clk,
  input  logic                nrst,
  mskaes_sr_colbuf_if.slave   bus,
  output logic                dbg_state_o
);
  localparam int W = 8 * D;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] s_q [4][4];

  logic         wr_en;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] in_col [4];
  logic [W-1:0] out_col [4];
  logic [1:0]   sel_col [4];

  assign in_col[0] = bus.in_a0;
  assign in_col[1] = bus.in_a1;
  assign in_col[2] = bus.in_a2;
  assign in_col[3] = bus.in_a3;

  // cnt is the fill column while filling and the presented column while draining.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          s_q[c][r] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < 4; r++) begin
        s_q[cnt_q][r] <= in_col[r];
      end
    end
  end

  // ShiftRows: row r of output column c comes from stored column (c + r) mod 4.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      sel_col[r] = cnt_q + 2'(r);
      out_col[r] = s_q[sel_col[r]][r];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_b0    = out_col[0];
  assign bus.out_b1    = out_col[1];
  assign bus.out_b2    = out_col[2];
  assign bus.out_b3    = out_col[3];
  assign bus.out_idx   = cnt_q;
  assign bus.out_last  = (state_q == DRAIN) && (cnt_q == 2'd3);

  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mskaes_sr_colbuf.sv
// Directed bench for mskaes_sr_colbuf: reset, ShiftRows order, share routing,
// back-pressure, mid-operation reset and back-to-back states.
`timescale 1ns/1ps
module tb_mskaes_sr_colbuf;
  localparam int D = 2;
  localparam int W = 8 * D;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic dbg_state;

  always #5 clk = ~clk;

  mskaes_sr_colbuf_if #(.D(D)) bus ();

  mskaes_sr_colbuf #(.D(D)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_m [4][4];
  logic [7:0]   tbl   [4][4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mask_byte(input logic [7:0] x, input logic [7:0] m);
    logic [W-1:0] v;
    for (int b = 0; b < 8; b++) begin
      v[b*2]   = x[b] ^ m[b];
      v[b*2+1] = m[b];
    end
    return v;
  endfunction

  function automatic logic [7:0] unmask_byte(input logic [W-1:0] v);
    logic [7:0] x;
    for (int b = 0; b < 8; b++) x[b] = v[b*2] ^ v[b*2+1];
    return x;
  endfunction

  function automatic logic [W-1:0] out_b(input int r);
    case (r)
      0:       return bus.out_b0;
      1:       return bus.out_b1;
      2:       return bus.out_b2;
      default: return bus.out_b3;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ones=1 loads plain 0xFF with zero masks; otherwise plain base+4c+r, random masks.
  task automatic push_state(input logic [7:0] base, input bit ones, input bit stall, input int ncol);
    logic [W-1:0] col [4];
    int guard;
    for (int c = 0; c < ncol; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (ones) col[r] = mask_byte(8'hFF, 8'h00);
        else      col[r] = mask_byte(base + 8'(4*c + r), 8'($urandom_range(0, 255)));
        exp_m[c][r] = col[r];
      end
      bus.in_a0 = col[0];
      bus.in_a1 = col[1];
      bus.in_a2 = col[2];
      bus.in_a3 = col[3];
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.in_valid  = 1'b0;
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
          check_eq("fill_idle_no_out", 32'(bus.out_valid), 32'd0);
        end
      end
      bus.in_valid = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        step();
        guard++;
      end
      check_eq("fill_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("fill_no_out", 32'(bus.out_valid), 32'd0);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_col(input int c, input bit use_tbl, input logic [7:0] base, input string ph);
    check_eq($sformatf("%s_valid_c%0d", ph, c), 32'(bus.out_valid), 32'd1);
    check_eq($sformatf("%s_in_ready_c%0d", ph, c), 32'(bus.in_ready), 32'd0);
    check_eq($sformatf("%s_idx_c%0d", ph, c), 32'(bus.out_idx), 32'(c));
    check_eq($sformatf("%s_last_c%0d", ph, c), 32'(bus.out_last), 32'(c == 3));
    for (int r = 0; r < 4; r++) begin
      check_eq($sformatf("%s_b_c%0d_r%0d", ph, c, r), 32'(out_b(r)), 32'(exp_m[(c + r) % 4][r]));
      if (use_tbl)
        check_eq($sformatf("%s_plain_c%0d_r%0d", ph, c, r), 32'(unmask_byte(out_b(r))),
                 32'(base | tbl[c][r]));
    end
  endtask

  // junk=1 holds in_valid high with a distinct column for columns 0..2 of the drain.
  task automatic drain_state(input bit use_tbl, input logic [7:0] base, input bit stall, input bit junk);
    if (junk) begin
      bus.in_a0 = 16'hA5A5;
      bus.in_a1 = 16'h5A5A;
      bus.in_a2 = 16'hC3C3;
      bus.in_a3 = 16'h3C3C;
    end
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = junk && (c < 3);
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.out_ready = 1'b0;
          check_col(c, use_tbl, base, "stall");
          step();
        end
      end
      bus.out_ready = 1'b1;
      check_col(c, use_tbl, base, "drain");
      step();
    end
    bus.in_valid = 1'b0;
    check_eq("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("b2b_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tbl[0][0] = 8'h00; tbl[0][1] = 8'h05; tbl[0][2] = 8'h0A; tbl[0][3] = 8'h0F;
    tbl[1][0] = 8'h04; tbl[1][1] = 8'h09; tbl[1][2] = 8'h0E; tbl[1][3] = 8'h03;
    tbl[2][0] = 8'h08; tbl[2][1] = 8'h0D; tbl[2][2] = 8'h02; tbl[2][3] = 8'h07;
    tbl[3][0] = 8'h0C; tbl[3][1] = 8'h01; tbl[3][2] = 8'h06; tbl[3][3] = 8'h0B;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a0 = '0; bus.in_a1 = '0; bus.in_a2 = '0; bus.in_a3 = '0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    step();

    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_b0", 32'(bus.out_b0), 32'd0);
    check_eq("rst_b1", 32'(bus.out_b1), 32'd0);
    check_eq("rst_b2", 32'(bus.out_b2), 32'd0);
    check_eq("rst_b3", 32'(bus.out_b3), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // Basic permutation, both sides always ready, then back-to-back second state.
    bus.out_ready = 1'b1;
    push_state(8'h00, 1'b0, 1'b0, 4);
    drain_state(1'b1, 8'h00, 1'b0, 1'b0);
    push_state(8'hF0, 1'b0, 1'b0, 4);
    drain_state(1'b1, 8'hF0, 1'b0, 1'b0);

    // Share routing: share0 all ones, share1 all zeros.
    push_state(8'h00, 1'b1, 1'b0, 4);
    drain_state(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("share_word", 32'(exp_m[2][1]), 32'h5555);

    // Back-pressure with spurious in_valid during drain, then a clean state.
    push_state(8'h00, 1'b0, 1'b1, 4);
    drain_state(1'b1, 8'h00, 1'b1, 1'b1);
    push_state(8'hF0, 1'b0, 1'b0, 4);
    drain_state(1'b1, 8'hF0, 1'b0, 1'b0);

    // Reset mid-fill discards the partial state.
    push_state(8'h80, 1'b0, 1'b0, 2);
    nrst = 1'b0;
    #2;
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_b0", 32'(bus.out_b0), 32'd0);
    check_eq("midrst_b1", 32'(bus.out_b1), 32'd0);
    step();
    nrst = 1'b1;
    step();
    check_eq("midrst_idx", 32'(bus.out_idx), 32'd0);
    check_eq("midrst_state", 32'(dbg_state), 32'd0);
    push_state(8'h00, 1'b0, 1'b0, 4);
    drain_state(1'b1, 8'h00, 1'b0, 1'b0);

    // Reset mid-drain.
    push_state(8'hF0, 1'b0, 1'b0, 4);
    step();
    nrst = 1'b0;
    #2;
    check_eq("drnrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("drnrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("drnrst_b2", 32'(bus.out_b2), 32'd0);
    step();
    nrst = 1'b1;
    step();
    push_state(8'h00, 1'b0, 1'b1, 4);
    drain_state(1'b1, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
